frac_op_engine: RTL

- Parametrised fractional-order operator core, successor to the single-mode RL integrator.
- Computes the Grünwald-Letnikov / Riemann-Liouville discrete convolution y[n] = sum_{k=0..DEPTH-1} w[k]*x[n-k] over a circular sample-history buffer.
- Runs a serial multiply-accumulate with two runtime-loadable coefficient banks: bank 0 for the integral, bank 1 for the derivative.
- Sits between the sample source and the board wrapper's output/indicator logic.

---
 rtl/frac_op_if.sv | 22 ++
 rtl/frac_op_engine.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/frac_op_if.sv
// Sample-in / result-out stream bundle for the fractional-order operator core.
interface frac_op_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     mode;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/frac_op_engine.sv
// Fractional-order operator: serial MAC of a circular sample history against one of two
// runtime-loadable coefficient banks (0 = integral, 1 = derivative), saturated output.
module frac_op_engine #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned COEF_FRAC = 14,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ACC_W     = DATA_W + COEF_W + $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  frac_op_if.slave                   s,
  input  logic                       coef_we,
  input  logic                       coef_bank,
  input  logic [$clog2(DEPTH)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       hist_clr,
  output logic                       busy,
  output logic                       sat_flag
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = DATA_W + COEF_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [1:0]               state;
  logic signed [DATA_W-1:0] hist  [DEPTH];
  logic signed [COEF_W-1:0] coef0 [DEPTH];
  logic signed [COEF_W-1:0] coef1 [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            k;
  logic                     bank;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;

  logic                     idle;
  logic                     accept;
  logic [AW-1:0]            rd_idx;
  logic [AW-1:0]            wr_idx;
  logic signed [COEF_W-1:0] tap_coef;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  shifted;
  logic                     sat_hi;
  logic                     sat_lo;

  always_comb begin
    idle     = (state == ST_IDLE);
    accept   = idle && s.in_valid;
    // Clear-with-accept writes the new sample at slot 0, since the clear wins first.
    wr_idx   = hist_clr ? '0 : wr_ptr;
    rd_idx   = wr_ptr - k;
    tap_coef = bank ? coef1[k] : coef0[k];
    prod     = tap_coef * hist[rd_idx];
    shifted  = acc >>> COEF_FRAC;
    sat_hi   = (shifted > OUT_MAX);
    sat_lo   = (shifted < OUT_MIN);
  end

  assign s.in_ready  = idle;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign busy        = !idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (idle) begin
      if (hist_clr) begin
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end
      if (accept) hist[wr_idx] <= s.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        coef0[i] <= '0;
        coef1[i] <= '0;
      end
    end else if (coef_we && idle && !accept) begin
      if (coef_bank) coef1[coef_addr] <= coef_data;
      else           coef0[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      k           <= '0;
      acc         <= '0;
      bank        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hist_clr) begin
            wr_ptr   <= '0;
            sat_flag <= 1'b0;
          end
          if (accept) begin
            bank  <= s.mode;
            acc   <= '0;
            k     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
          k   <= k + 1'b1;
          if (k == AW'(DEPTH - 1)) state <= ST_OUT;
        end
        ST_OUT: begin
          out_valid_q <= 1'b1;
          if (sat_hi)      out_data_q <= OUT_MAX[DATA_W-1:0];
          else if (sat_lo) out_data_q <= OUT_MIN[DATA_W-1:0];
          else             out_data_q <= shifted[DATA_W-1:0];
          if (sat_hi || sat_lo) sat_flag <= 1'b1;
          state <= ST_HOLD;
        end
        default: begin
          if (s.out_ready) begin
            out_valid_q <= 1'b0;
            wr_ptr      <= wr_ptr + 1'b1;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule
